// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave that turns host frames (command word + data words) into
// register-bus reads and writes with an auto-incrementing word address.
module spi_bus_bridge #(
  parameter int READ_LAT    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        sclr,
  input  logic        sclk,
  input  logic        csn,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [15:0] rdaddr,
  output logic [15:0] wraddr,
  output logic [1:0]  be,
  output logic        write,
  output logic [15:0] wrdata,
  input  logic [15:0] rddata,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_DATA = 3'd4
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(READ_LAT);

  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   sclk_s, csn_s, mosi_s;
  logic                   sclk_rise_s, sclk_fall_s, csn_fall_s, csn_rise_s;
  logic                   word_done_s;
  logic [15:0]            rx_word_d;

  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [3:0]  lat_cnt_q;
  logic [15:0] rx_q;
  logic [15:0] tx_q;
  logic [14:0] addr_q;
  logic        miso_q, miso_oe_q, busy_q, frame_err_q, write_q;
  logic [15:0] rdaddr_q, wraddr_q, wrdata_q;
  logic [1:0]  be_q;

  // Input synchronizers. csn resets to "low" so a csn already low when reset
  // releases is not mistaken for a new falling edge.
  always_ff @(posedge clk) begin
    if (sclr) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  // Edge pulses and the word being assembled on this rise
  always_comb begin
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    csn_s       = csn_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise_s = sclk_s & ~sclk_prev_q;
    sclk_fall_s = ~sclk_s & sclk_prev_q;
    csn_fall_s  = ~csn_s & csn_prev_q;
    csn_rise_s  = csn_s & ~csn_prev_q;
    rx_word_d   = {rx_q[14:0], mosi_s};
    word_done_s = sclk_rise_s && (bit_cnt_q == 4'd15);
  end

  // Frame FSM with all bus and SPI outputs registered
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      lat_cnt_q   <= 4'd0;
      rx_q        <= 16'd0;
      tx_q        <= 16'd0;
      addr_q      <= 15'd0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      write_q     <= 1'b0;
      be_q        <= 2'b00;
      rdaddr_q    <= 16'd0;
      wraddr_q    <= 16'd0;
      wrdata_q    <= 16'd0;
    end else begin
      write_q <= 1'b0;
      be_q    <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (csn_fall_s) begin
            state_q     <= ST_CMD;
            busy_q      <= 1'b1;
            miso_oe_q   <= 1'b1;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
            bit_cnt_q   <= 4'd0;
          end
        end
        ST_CMD: begin
          if (sclk_rise_s) begin
            rx_q      <= rx_word_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              addr_q <= rx_word_d[14:0];
              if (rx_word_d[15]) begin
                state_q <= ST_WR_DATA;
              end else begin
                state_q   <= ST_RD_WAIT;
                rdaddr_q  <= {1'b0, rx_word_d[14:0]};
                lat_cnt_q <= 4'd0;
              end
            end
          end
        end
        ST_RD_WAIT: begin
          // rdaddr has been stable long enough: capture and prefetch the next word
          if (lat_cnt_q == LAT_LAST) begin
            tx_q     <= rddata;
            addr_q   <= addr_q + 15'd1;
            rdaddr_q <= {1'b0, addr_q + 15'd1};
            state_q  <= ST_RD_DATA;
          end else begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
          end
        end
        ST_RD_DATA: begin
          if (sclk_fall_s) begin
            miso_q <= tx_q[15];
            tx_q   <= {tx_q[14:0], 1'b0};
          end
          if (sclk_rise_s) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              state_q   <= ST_RD_WAIT;
              lat_cnt_q <= 4'd0;
            end
          end
        end
        ST_WR_DATA: begin
          if (sclk_rise_s) begin
            rx_q      <= rx_word_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              write_q  <= 1'b1;
              be_q     <= 2'b11;
              wraddr_q <= {1'b0, addr_q};
              wrdata_q <= rx_word_d;
              addr_q   <= addr_q + 15'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // csn high ends any frame; a word completing on this very cycle still counts
      if (csn_rise_s && (state_q != ST_IDLE)) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        bit_cnt_q <= 4'd0;
        if ((bit_cnt_q != 4'd0) && !word_done_s) begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign rdaddr    = rdaddr_q;
  assign wraddr    = wraddr_q;
  assign be        = be_q;
  assign write     = write_q;
  assign wrdata    = wrdata_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule
